// File: rtl/exe_stage.sv
// Execute stage: Val2 generation (immediate rotate / memory offset / register
// shift), ALU with NZCV flags, branch target, status register and the
// registered EX/MEM pipeline stage.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_enable_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_enable_in,
  input  logic        S_in,
  input  logic [3:0]  exec_cmd_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic        immediate_in,
  input  logic [11:0] Shift_operand_in,
  input  logic [23:0] Signed_immediate_24_in,
  input  logic [3:0]  Dest_in,
  output logic [3:0]  status,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic        wb_enable_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [3:0]  Dest_out
);

  // status layout {N,Z,C,V}
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  logic [3:0]  status_q, status_d;
  logic        wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
  logic [31:0] alu_q, alu_d, sd_q, sd_d;
  logic [3:0]  dest_q, dest_d;

  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [3:0]  nzcv;

  // Branch resolves in EX, same cycle, so the upstream flush lands on the next edge
  assign branch_taken   = branch_enable_in;
  assign branch_address = PC_in + {{6{Signed_immediate_24_in[23]}}, Signed_immediate_24_in, 2'b00};

  // Val2: immediate rotate beats memory offset beats register shift
  always_comb begin
    logic [63:0] dbl;
    logic [4:0]  rot;
    logic [4:0]  amt;
    val2 = Val_Rm_in;
    dbl  = '0;
    rot  = {Shift_operand_in[11:8], 1'b0};
    amt  = Shift_operand_in[11:7];
    if (immediate_in) begin
      dbl  = {24'd0, Shift_operand_in[7:0], 24'd0, Shift_operand_in[7:0]} >> rot;
      val2 = dbl[31:0];
    end else if (mem_read_in | mem_write_in) begin
      val2 = {20'd0, Shift_operand_in};
    end else begin
      unique case (Shift_operand_in[6:5])
        2'b00: val2 = Val_Rm_in << amt;
        2'b01: val2 = Val_Rm_in >> amt;
        2'b10: val2 = $unsigned($signed(Val_Rm_in) >>> amt);
        default: begin
          dbl  = {Val_Rm_in, Val_Rm_in} >> amt;
          val2 = dbl[31:0];
        end
      endcase
    end
  end

  // ALU and flags; subtraction is A + ~B + carry so C=1 means no borrow
  always_comb begin
    logic [32:0] sum;
    logic [31:0] b_eff;
    logic        cin;
    logic        arith;
    b_eff   = val2;
    cin     = 1'b0;
    arith   = 1'b0;
    alu_res = '0;
    unique case (exec_cmd_in)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; cin = status_q[C_BIT]; end
      4'b0100: begin arith = 1'b1; b_eff = ~val2; cin = 1'b1; end
      4'b0101: begin arith = 1'b1; b_eff = ~val2; cin = status_q[C_BIT]; end
      4'b0110: alu_res = Val_Rn_in & val2;
      4'b0111: alu_res = Val_Rn_in | val2;
      4'b1000: alu_res = Val_Rn_in ^ val2;
      default: alu_res = '0;
    endcase
    sum = {1'b0, Val_Rn_in} + {1'b0, b_eff} + {32'd0, cin};
    if (arith) alu_res = sum[31:0];
    nzcv[3] = alu_res[31];
    nzcv[2] = (alu_res == 32'd0);
    nzcv[1] = arith ? sum[32] : status_q[C_BIT];
    nzcv[0] = arith ? ((Val_Rn_in[31] == b_eff[31]) && (alu_res[31] != Val_Rn_in[31]))
                    : status_q[V_BIT];
  end

  // Next-state for status and EX/MEM; freeze holds everything
  always_comb begin
    status_d = status_q;
    wb_d     = wb_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    alu_d    = alu_q;
    sd_d     = sd_q;
    dest_d   = dest_q;
    if (!freeze) begin
      if (S_in && !branch_enable_in) status_d = nzcv;
      wb_d   = wb_enable_in;
      mr_d   = mem_read_in;
      mw_d   = mem_write_in;
      alu_d  = alu_res;
      sd_d   = Val_Rm_in;
      dest_d = Dest_in;
    end
  end

  // Status and EX/MEM registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
      wb_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      alu_q    <= '0;
      sd_q     <= '0;
      dest_q   <= '0;
    end else begin
      status_q <= status_d;
      wb_q     <= wb_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      alu_q    <= alu_d;
      sd_q     <= sd_d;
      dest_q   <= dest_d;
    end
  end

  assign status         = status_q;
  assign wb_enable_out  = wb_q;
  assign mem_read_out   = mr_q;
  assign mem_write_out  = mw_q;
  assign alu_result_out = alu_q;
  assign store_data_out = sd_q;
  assign Dest_out       = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, wb_enable_in, mem_read_in, mem_write_in, branch_enable_in, S_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic        immediate_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_immediate_24_in;
  logic [3:0]  Dest_in;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        wb_enable_out, mem_read_out, mem_write_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [3:0]  Dest_out;

  int n_pass = 0;
  int n_total = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .branch_enable_in(branch_enable_in), .S_in(S_in), .exec_cmd_in(exec_cmd_in),
    .PC_in(PC_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
    .immediate_in(immediate_in), .Shift_operand_in(Shift_operand_in),
    .Signed_immediate_24_in(Signed_immediate_24_in), .Dest_in(Dest_in),
    .status(status), .branch_taken(branch_taken), .branch_address(branch_address),
    .wb_enable_out(wb_enable_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .Dest_out(Dest_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
    if (r == 0) return x;
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic logic [31:0] m_val2(input logic imm, input logic memrw,
                                         input logic [11:0] so, input logic [31:0] rm);
    int amt;
    amt = int'(so[11:7]);
    if (imm) return ror32({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    if (memrw) return {20'd0, so};
    case (so[6:5])
      2'b00: return rm << amt;
      2'b01: return rm >> amt;
      2'b10: return $unsigned($signed(rm) >>> amt);
      default: return ror32(rm, amt);
    endcase
  endfunction

  // returns {result, N, Z, C, V}
  function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] st);
    longint ua, ub, sa, sb, exact;
    logic [31:0] r;
    logic c, v, cin, arith;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = st[1]; c = st[1]; v = st[0]; arith = 1'b1; exact = 0; r = 0;
    case (cmd)
      4'd2: begin r = a + b;       c = (ua + ub) > 64'hFFFF_FFFF;       exact = sa + sb; end
      4'd3: begin r = a + b + 32'(cin); c = (ua + ub + longint'(cin)) > 64'hFFFF_FFFF;
                  exact = sa + sb + longint'(cin); end
      4'd4: begin r = a - b;       c = (ua >= ub);                       exact = sa - sb; end
      4'd5: begin r = a - b - 32'(!cin); c = (ua >= ub + longint'(!cin));
                  exact = sa - sb - longint'(!cin); end
      default: begin
        arith = 1'b0;
        case (cmd)
          4'd1: r = b;
          4'd9: r = ~b;
          4'd6: r = a & b;
          4'd7: r = a | b;
          4'd8: r = a ^ b;
          default: r = 0;
        endcase
      end
    endcase
    if (arith) v = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    return {r, r[31], (r == 0), c, v};
  endfunction

  // ---------------- helpers ----------------
  task automatic set_nop();
    freeze = 0; wb_enable_in = 0; mem_read_in = 0; mem_write_in = 0;
    branch_enable_in = 0; S_in = 0; exec_cmd_in = 0; PC_in = 0;
    Val_Rn_in = 0; Val_Rm_in = 0; immediate_in = 0; Shift_operand_in = 0;
    Signed_immediate_24_in = 0; Dest_in = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_nop();
    rst = 0;
    #12;
    n_total++;
    if ({status, wb_enable_out, mem_read_out, mem_write_out, alu_result_out, store_data_out, Dest_out} !== '0)
      $display("FAIL reset_state: got st=%h alu=%h sd=%h dst=%h ctl=%b%b%b, want all zero",
               status, alu_result_out, store_data_out, Dest_out, wb_enable_out, mem_read_out, mem_write_out);
    else n_pass++;
    @(negedge clk); rst = 1;
    tick();
    n_total++;
    if ({status, alu_result_out} !== '0) $display("FAIL reset_release: st=%h alu=%h want 0", status, alu_result_out);
    else n_pass++;
  endtask

  task automatic test_add_overflow();
    set_nop();
    exec_cmd_in = 4'b0010; Val_Rn_in = 32'h7FFF_FFFF; immediate_in = 1; Shift_operand_in = 12'h001;
    S_in = 1; wb_enable_in = 1; Dest_in = 4'd3;
    tick();
    n_total++;
    if (alu_result_out !== 32'h8000_0000) $display("FAIL add_ovf_result: got %h want 80000000", alu_result_out);
    else n_pass++;
    n_total++;
    if (status !== 4'b1001) $display("FAIL add_ovf_status: got %b want 1001", status);
    else n_pass++;
    n_total++;
    if ({wb_enable_out, Dest_out} !== {1'b1, 4'd3}) $display("FAIL add_wb_dest: got %b/%h want 1/3", wb_enable_out, Dest_out);
    else n_pass++;
  endtask

  task automatic test_sub_sbc();
    set_nop();
    exec_cmd_in = 4'b0100; Val_Rn_in = 5; Val_Rm_in = 5; S_in = 1;
    tick();
    n_total++;
    if (alu_result_out !== 0 || status !== 4'b0110)
      $display("FAIL sub_eq: got res=%h st=%b want 0/0110", alu_result_out, status);
    else n_pass++;
    exec_cmd_in = 4'b0101; Val_Rn_in = 10; Val_Rm_in = 3; S_in = 0;
    tick();
    n_total++;
    if (alu_result_out !== 32'd7) $display("FAIL sbc_carry_in: got %h want 7", alu_result_out);
    else n_pass++;
  endtask

  task automatic test_imm_rotate();
    set_nop();
    exec_cmd_in = 4'b0001; immediate_in = 1; Shift_operand_in = 12'h4FF;
    tick();
    n_total++;
    if (alu_result_out !== 32'hFF00_0000) $display("FAIL imm_rotate: got %h want ff000000", alu_result_out);
    else n_pass++;
    n_total++;
    if (status !== 4'b0110) $display("FAIL mov_nos_status: got %b want 0110", status);
    else n_pass++;
  endtask

  task automatic test_asr_ldr();
    set_nop();
    exec_cmd_in = 4'b0001; Val_Rm_in = 32'h8000_0000; Shift_operand_in = 12'h7C0;
    tick();
    n_total++;
    if (alu_result_out !== 32'hFFFF_0000) $display("FAIL asr15: got %h want ffff0000", alu_result_out);
    else n_pass++;
    set_nop();
    exec_cmd_in = 4'b0010; mem_read_in = 1; wb_enable_in = 1; Val_Rn_in = 32'h100;
    Val_Rm_in = 32'hDEAD_BEEF; Shift_operand_in = 12'h004;
    tick();
    n_total++;
    if (alu_result_out !== 32'h104 || mem_read_out !== 1'b1 || store_data_out !== 32'hDEAD_BEEF)
      $display("FAIL ldr_addr: got addr=%h mr=%b sd=%h want 104/1/deadbeef", alu_result_out, mem_read_out, store_data_out);
    else n_pass++;
  endtask

  task automatic test_branch();
    set_nop();
    branch_enable_in = 1; PC_in = 32'h20; Signed_immediate_24_in = 24'hFFFFFE;
    S_in = 1; exec_cmd_in = 4'b0010; Val_Rn_in = 32'h8000_0000; Val_Rm_in = 32'h8000_0000;
    #1;
    n_total++;
    if (branch_taken !== 1'b1 || branch_address !== 32'h18)
      $display("FAIL branch_comb: got tk=%b addr=%h want 1/18", branch_taken, branch_address);
    else n_pass++;
    tick();
    n_total++;
    if (status !== 4'b0110) $display("FAIL branch_status_hold: got %b want 0110", status);
    else n_pass++;
  endtask

  task automatic test_freeze();
    logic [31:0] held;
    set_nop();
    exec_cmd_in = 4'b0111; Val_Rn_in = 32'h00F0; immediate_in = 1; Shift_operand_in = 12'h00F;
    wb_enable_in = 1; Dest_in = 4'd9; S_in = 1;
    tick();
    held = 32'h00FF;
    n_total++;
    if (alu_result_out !== held || status !== 4'b0010)
      $display("FAIL orr_setup: got %h st=%b want 000000ff/0010", alu_result_out, status);
    else n_pass++;
    freeze = 1;
    for (int i = 0; i < 2; i++) begin
      exec_cmd_in = 4'b0100; Val_Rn_in = 32'(i); Shift_operand_in = 12'h0FF; Dest_in = 4'(i);
      wb_enable_in = 0; mem_write_in = 1; branch_enable_in = 1; S_in = 1;
      #2;
      n_total++;
      if (branch_taken !== 1'b1) $display("FAIL freeze_branch: got %b want 1", branch_taken);
      else n_pass++;
      tick();
      n_total++;
      if (alu_result_out !== held || status !== 4'b0010 || Dest_out !== 4'd9 ||
          wb_enable_out !== 1'b1 || mem_write_out !== 1'b0)
        $display("FAIL freeze_hold: got alu=%h st=%b dst=%h wb=%b mw=%b want ff/0010/9/1/0",
                 alu_result_out, status, Dest_out, wb_enable_out, mem_write_out);
      else n_pass++;
    end
    #3 rst = 0;
    #1;
    n_total++;
    if ({status, wb_enable_out, mem_read_out, mem_write_out, alu_result_out, store_data_out, Dest_out} !== '0)
      $display("FAIL async_reset: got alu=%h st=%b dst=%h want all zero", alu_result_out, status, Dest_out);
    else n_pass++;
    @(negedge clk); rst = 1; set_nop();
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  e_st;
    logic [31:0] e_alu, e_sd, v2;
    logic [3:0]  e_dst;
    logic [2:0]  e_ctl;
    logic [35:0] r;
    int errs;
    e_st = 0; e_alu = 0; e_sd = 0; e_dst = 0; e_ctl = 0; errs = 0;
    for (int i = 0; i < 400; i++) begin
      freeze           = ($urandom_range(0, 7) == 0);
      wb_enable_in     = 1'($urandom);
      mem_read_in      = ($urandom_range(0, 5) == 0);
      mem_write_in     = ($urandom_range(0, 5) == 0);
      branch_enable_in = ($urandom_range(0, 6) == 0);
      S_in             = 1'($urandom);
      exec_cmd_in      = 4'($urandom);
      PC_in            = $urandom;
      Val_Rn_in        = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      Val_Rm_in        = $urandom;
      immediate_in     = 1'($urandom);
      Shift_operand_in = 12'($urandom);
      Signed_immediate_24_in = 24'($urandom);
      Dest_in          = 4'($urandom);
      #1;
      n_total++;
      if (branch_taken !== branch_enable_in ||
          branch_address !== PC_in + 32'($signed(Signed_immediate_24_in)) * 4) begin
        if (errs < 10) $display("FAIL rand_branch[%0d]: got tk=%b addr=%h want tk=%b addr=%h", i,
                                branch_taken, branch_address, branch_enable_in,
                                PC_in + 32'($signed(Signed_immediate_24_in)) * 4);
        errs++;
      end else n_pass++;
      v2 = m_val2(immediate_in, mem_read_in | mem_write_in, Shift_operand_in, Val_Rm_in);
      r  = m_alu(exec_cmd_in, Val_Rn_in, v2, e_st);
      if (!freeze) begin
        if (S_in && !branch_enable_in) e_st = r[3:0];
        e_alu = r[35:4]; e_sd = Val_Rm_in; e_dst = Dest_in;
        e_ctl = {wb_enable_in, mem_read_in, mem_write_in};
      end
      tick();
      n_total++;
      if (status !== e_st || alu_result_out !== e_alu || store_data_out !== e_sd || Dest_out !== e_dst ||
          {wb_enable_out, mem_read_out, mem_write_out} !== e_ctl) begin
        if (errs < 10) $display("FAIL rand_exmem[%0d]: got st=%b alu=%h sd=%h dst=%h ctl=%b want st=%b alu=%h sd=%h dst=%h ctl=%b",
                                i, status, alu_result_out, store_data_out, Dest_out,
                                {wb_enable_out, mem_read_out, mem_write_out}, e_st, e_alu, e_sd, e_dst, e_ctl);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_sbc();
    test_imm_rotate();
    test_asr_ldr();
    test_branch();
    test_freeze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
